// File: rtl/decode_pkg.sv
// Shared definitions for the instruction decode stage.
// - opcode_e   : 4-bit opcode encoding
// - field bit positions of the 24-bit instruction word
// - dec_ctrl_t : decoded fields and control bits carried through the skid buffer
package decode_pkg;

    localparam int unsigned InstrW  = 24;
    localparam int unsigned Imm8W   = 8;

    localparam int unsigned OpMsb   = 23;
    localparam int unsigned OpLsb   = 20;
    localparam int unsigned RdMsb   = 19;
    localparam int unsigned RdLsb   = 16;
    localparam int unsigned Rs1Msb  = 15;
    localparam int unsigned Rs1Lsb  = 12;
    localparam int unsigned Rs2Msb  = 11;
    localparam int unsigned Rs2Lsb  = 8;
    localparam int unsigned Imm8Msb = 7;
    localparam int unsigned Imm8Lsb = 0;

    typedef enum logic [3:0] {
        OpNop   = 4'h0,
        OpAdd   = 4'h1,
        OpSub   = 4'h2,
        OpAnd   = 4'h3,
        OpOr    = 4'h4,
        OpXor   = 4'h5,
        OpAddi  = 4'h6,
        OpLdi   = 4'h7,
        OpLd    = 4'h8,
        OpSt    = 4'h9,
        OpBeq   = 4'hA,
        OpBne   = 4'hB,
        OpJmp   = 4'hC,
        OpRsvdD = 4'hD,
        OpRsvdE = 4'hE,
        OpHalt  = 4'hF
    } opcode_e;

    typedef struct packed {
        opcode_e          op;
        logic [3:0]       rd;
        logic [3:0]       rs1;
        logic [3:0]       rs2;
        logic [Imm8W-1:0] imm8;
        logic             reg_we;
        logic             mem_re;
        logic             mem_we;
        logic             is_branch;
        logic             is_jump;
        logic             is_halt;
        logic             illegal;
    } dec_ctrl_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decoder: splits a 24-bit instruction word into its
// register/immediate fields and derives the control bits.
// Ports:
//   instr_i : raw instruction word
//   dec_o   : decoded fields and controls (all controls 0 except illegal for D/E)
module instr_decoder
    import decode_pkg::*;
(
    input  logic [InstrW-1:0] instr_i,
    output dec_ctrl_t         dec_o
);

    opcode_e op;

    assign op = opcode_e'(instr_i[OpMsb:OpLsb]);

    always_comb begin
        dec_o      = '0;
        dec_o.op   = op;
        dec_o.rd   = instr_i[RdMsb:RdLsb];
        dec_o.rs1  = instr_i[Rs1Msb:Rs1Lsb];
        dec_o.rs2  = instr_i[Rs2Msb:Rs2Lsb];
        dec_o.imm8 = instr_i[Imm8Msb:Imm8Lsb];

        unique case (op)
            OpAdd, OpSub, OpAnd, OpOr, OpXor, OpAddi, OpLdi: dec_o.reg_we = 1'b1;
            OpLd: begin
                dec_o.reg_we = 1'b1;
                dec_o.mem_re = 1'b1;
            end
            OpSt:             dec_o.mem_we    = 1'b1;
            OpBeq, OpBne:     dec_o.is_branch = 1'b1;
            OpJmp:            dec_o.is_jump   = 1'b1;
            OpHalt:           dec_o.is_halt   = 1'b1;
            OpRsvdD, OpRsvdE: dec_o.illegal   = 1'b1;
            default:          ;
        endcase
    end

endmodule

// File: rtl/instr_decode_stage.sv
// Decode stage: accepts instruction words over valid/ready, decodes them on the
// way in and holds up to two decoded entries (main + skid). Outputs are driven
// straight from the main entry flops. A HALT instruction, once accepted, stops
// further acceptance until a flush; entries already held still drain.
// Ports:
//   clk, reset (async, active-low)
//   in_valid/in_instr/in_pc/in_ready  : fetch side handshake
//   flush                             : drop all held entries, leave HALTED
//   out_valid/out_ready               : execute side handshake
//   out_pc/out_op/out_rd/out_rs1/out_rs2/out_imm and control bits : decoded entry
//   halted                            : stage is in the HALTED state
module instr_decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned PC_W   = 8,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [InstrW-1:0] in_instr,
    input  logic [PC_W-1:0]   in_pc,
    output logic              in_ready,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [3:0]        out_op,
    output logic [3:0]        out_rd,
    output logic [3:0]        out_rs1,
    output logic [3:0]        out_rs2,
    output logic [DATA_W-1:0] out_imm,
    output logic              out_reg_we,
    output logic              out_mem_re,
    output logic              out_mem_we,
    output logic              out_is_branch,
    output logic              out_is_jump,
    output logic              out_is_halt,
    output logic              out_illegal,
    output logic              halted
);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        dec_ctrl_t       ctrl;
    } entry_t;

    typedef enum logic {StRun, StHalted} state_e;

    dec_ctrl_t in_dec;
    entry_t    in_entry;

    instr_decoder u_decoder (
        .instr_i (in_instr),
        .dec_o   (in_dec)
    );

    assign in_entry = '{pc: in_pc, ctrl: in_dec};

    entry_t main_q, main_d, skid_q, skid_d;
    logic   main_valid_q, main_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   in_ready_q, in_ready_d;
    state_e state_q, state_d;

    logic in_xfer, out_xfer;

    // A word offered alongside flush is dropped.
    assign in_xfer  = in_valid & in_ready_q & ~flush;
    assign out_xfer = main_valid_q & out_ready;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        state_d      = state_q;

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            state_d      = StRun;
        end else begin
            // in_ready_q is low whenever skid is occupied, so in_xfer and
            // skid_valid_q are never both set.
            if (out_xfer) begin
                if (skid_valid_q) begin
                    main_d       = skid_q;
                    main_valid_d = 1'b1;
                    skid_valid_d = 1'b0;
                end else if (in_xfer) begin
                    main_d       = in_entry;
                    main_valid_d = 1'b1;
                end else begin
                    main_valid_d = 1'b0;
                end
            end else if (in_xfer) begin
                if (main_valid_q) begin
                    skid_d       = in_entry;
                    skid_valid_d = 1'b1;
                end else begin
                    main_d       = in_entry;
                    main_valid_d = 1'b1;
                end
            end

            if (in_xfer && in_dec.is_halt) begin
                state_d = StHalted;
            end
        end

        // Registered ready: depends only on next state, never on out_ready.
        in_ready_d = ~skid_valid_d & (state_d == StRun);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            state_q      <= StRun;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            state_q      <= state_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign halted        = (state_q == StHalted);
    assign out_valid     = main_valid_q;
    assign out_pc        = main_q.pc;
    assign out_op        = main_q.ctrl.op;
    assign out_rd        = main_q.ctrl.rd;
    assign out_rs1       = main_q.ctrl.rs1;
    assign out_rs2       = main_q.ctrl.rs2;
    assign out_imm       = {{(DATA_W - Imm8W){main_q.ctrl.imm8[Imm8W-1]}}, main_q.ctrl.imm8};
    assign out_reg_we    = main_q.ctrl.reg_we;
    assign out_mem_re    = main_q.ctrl.mem_re;
    assign out_mem_we    = main_q.ctrl.mem_we;
    assign out_is_branch = main_q.ctrl.is_branch;
    assign out_is_jump   = main_q.ctrl.is_jump;
    assign out_is_halt   = main_q.ctrl.is_halt;
    assign out_illegal   = main_q.ctrl.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Self-checking bench for instr_decode_stage: decode table, directed handshake
// sequences (stall, halt, flush, async reset) and a randomized run, all checked
// against a queue-based reference model.
module tb_instr_decode_stage;

    localparam int unsigned PC_W   = 8;
    localparam int unsigned DATA_W = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [23:0]       in_instr;
    logic [PC_W-1:0]   in_pc;
    logic              in_ready;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc;
    logic [3:0]        out_op, out_rd, out_rs1, out_rs2;
    logic [DATA_W-1:0] out_imm;
    logic              out_reg_we, out_mem_re, out_mem_we;
    logic              out_is_branch, out_is_jump, out_is_halt, out_illegal;
    logic              halted;

    instr_decode_stage #(.PC_W(PC_W), .DATA_W(DATA_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_instr      (in_instr),
        .in_pc         (in_pc),
        .in_ready      (in_ready),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_op        (out_op),
        .out_rd        (out_rd),
        .out_rs1       (out_rs1),
        .out_rs2       (out_rs2),
        .out_imm       (out_imm),
        .out_reg_we    (out_reg_we),
        .out_mem_re    (out_mem_re),
        .out_mem_we    (out_mem_we),
        .out_is_branch (out_is_branch),
        .out_is_jump   (out_is_jump),
        .out_is_halt   (out_is_halt),
        .out_illegal   (out_illegal),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    // Reference model: queue of accepted, not-yet-consumed words.
    typedef struct packed {
        logic [23:0]     instr;
        logic [PC_W-1:0] pc;
    } ent_t;

    ent_t            mq[$];
    bit              m_halted;
    logic [PC_W-1:0] seen[$];
    int              n_checks;
    int              n_fail;

    typedef struct packed {
        logic [23:0] instr;
        logic [6:0]  ctrl;  // reg_we, mem_re, mem_we, branch, jump, halt, illegal
        logic [15:0] imm;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] ref_ctrl(input logic [3:0] op);
        int o;
        logic [6:0] c;
        o    = int'(op);
        c    = '0;
        c[6] = (o >= 1 && o <= 8);
        c[5] = (o == 8);
        c[4] = (o == 9);
        c[3] = (o == 10 || o == 11);
        c[2] = (o == 12);
        c[1] = (o == 15);
        c[0] = (o == 13 || o == 14);
        return c;
    endfunction

    function automatic logic [15:0] ref_imm(input logic [7:0] b);
        int v;
        v = (int'(b) >= 128) ? int'(b) - 256 : int'(b);
        return 16'(v);
    endfunction

    function automatic logic [6:0] dut_ctrl();
        return {out_reg_we, out_mem_re, out_mem_we, out_is_branch, out_is_jump,
                out_is_halt, out_illegal};
    endfunction

    task automatic check_state(input string tag);
        ent_t e;
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(mq.size() > 0));
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(mq.size() < 2 && !m_halted));
        chk({tag, ".halted"}, 32'(halted), 32'(m_halted));
        if (mq.size() > 0) begin
            e = mq[0];
            chk({tag, ".pc"}, 32'(out_pc), 32'(e.pc));
            chk({tag, ".fields"}, {out_op, out_rd, out_rs1, out_rs2, out_imm},
                {e.instr[23:8], ref_imm(e.instr[7:0])});
            chk({tag, ".ctrl"}, 32'(dut_ctrl()), 32'(ref_ctrl(e.instr[23:20])));
        end
    endtask

    // One clock: drive inputs now, advance the model at the edge, check at negedge.
    task automatic cycle(input logic v, input logic [23:0] ins, input logic [PC_W-1:0] pc,
                         input logic ordy, input logic fl, input string tag);
        bit in_x, out_x;
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        in_x  = v && (mq.size() < 2) && !m_halted && !fl;
        out_x = (mq.size() > 0) && ordy;
        if (out_valid && out_ready) seen.push_back(out_pc);
        @(posedge clk);
        if (fl) begin
            mq.delete();
            m_halted = 1'b0;
        end else begin
            if (out_x) void'(mq.pop_front());
            if (in_x) begin
                mq.push_back('{instr: ins, pc: pc});
                if (ins[23:20] == 4'hF) m_halted = 1'b1;
            end
        end
        @(negedge clk);
        check_state(tag);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_halted = 1'b0;

        tbl[0]  = '{24'h134500, 7'b1000000, 16'h0000};
        tbl[1]  = '{24'h6210FF, 7'b1000000, 16'hFFFF};
        tbl[2]  = '{24'h7A0080, 7'b1000000, 16'hFF80};
        tbl[3]  = '{24'h812005, 7'b1100000, 16'h0005};
        tbl[4]  = '{24'h93450A, 7'b0010000, 16'h000A};
        tbl[5]  = '{24'hA012FE, 7'b0001000, 16'hFFFE};
        tbl[6]  = '{24'hB34501, 7'b0001000, 16'h0001};
        tbl[7]  = '{24'hC00010, 7'b0000100, 16'h0010};
        tbl[8]  = '{24'hD00000, 7'b0000001, 16'h0000};
        tbl[9]  = '{24'hE12345, 7'b0000001, 16'h0045};
        tbl[10] = '{24'hF00000, 7'b0000010, 16'h0000};
        tbl[11] = '{24'h000000, 7'b0000000, 16'h0000};

        reset     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        out_ready = 1'b0;
        flush     = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.halted", 32'(halted), 32'd0);
        chk("rst.fields", {out_op, out_rd, out_rs1, out_rs2, out_imm}, 32'd0);
        chk("rst.pc", 32'(out_pc), 32'd0);
        chk("rst.ctrl", 32'(dut_ctrl()), 32'd0);
        reset = 1'b1;

        // ADD then ADDI, one-cycle latency, full throughput
        cycle(1'b1, 24'h134500, 8'd0, 1'b1, 1'b0, "add");
        chk("lat.op_add", 32'(out_op), 32'h1);
        cycle(1'b1, 24'h6210FF, 8'd1, 1'b1, 1'b0, "addi");
        chk("addi.imm", 32'(out_imm), 32'hFFFF);
        chk("addi.reg_we", 32'(out_reg_we), 32'd1);
        chk("addi.pc", 32'(out_pc), 32'd1);
        cycle(1'b0, 24'h0, 8'd0, 1'b1, 1'b0, "drain");

        // Stall: three words with out_ready low, then release
        seen.delete();
        cycle(1'b1, 24'h111101, 8'd10, 1'b0, 1'b0, "stall0");
        chk("stall.ready_after1", 32'(in_ready), 32'd1);
        cycle(1'b1, 24'h122202, 8'd11, 1'b0, 1'b0, "stall1");
        chk("stall.ready_after2", 32'(in_ready), 32'd0);
        cycle(1'b1, 24'h133303, 8'd12, 1'b0, 1'b0, "stall2");
        chk("stall.hold_pc", 32'(out_pc), 32'd10);
        cycle(1'b1, 24'h133303, 8'd12, 1'b1, 1'b0, "rel0");
        cycle(1'b1, 24'h133303, 8'd12, 1'b1, 1'b0, "rel1");
        cycle(1'b0, 24'h0, 8'd0, 1'b1, 1'b0, "rel2");
        cycle(1'b0, 24'h0, 8'd0, 1'b1, 1'b0, "rel3");
        chk("order.count", 32'(seen.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("order.pc%0d", i), 32'(seen[i]), 32'(10 + i));
        end

        // Decode table
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, tbl[i].instr, PC_W'(20 + i), 1'b1, 1'b0, "tbl");
            chk($sformatf("tbl%0d.ctrl", i), 32'(dut_ctrl()), 32'(tbl[i].ctrl));
            chk($sformatf("tbl%0d.imm", i), 32'(out_imm), 32'(tbl[i].imm));
            cycle(1'b0, 24'h0, 8'd0, 1'b1, 1'b1, "tbl_flush");
        end

        // HALT blocks the following ADD until flush
        cycle(1'b1, 24'hF00000, 8'd40, 1'b1, 1'b0, "halt");
        chk("halt.halted", 32'(halted), 32'd1);
        chk("halt.in_ready", 32'(in_ready), 32'd0);
        chk("halt.is_halt", 32'(out_is_halt), 32'd1);
        cycle(1'b1, 24'h134500, 8'd41, 1'b1, 1'b0, "halt_add0");
        chk("halt.add_blocked0", 32'(out_valid), 32'd0);
        cycle(1'b1, 24'h134500, 8'd41, 1'b1, 1'b0, "halt_add1");
        chk("halt.add_blocked1", 32'(out_valid), 32'd0);
        cycle(1'b0, 24'h0, 8'd0, 1'b1, 1'b1, "halt_flush");
        chk("halt.flush_halted", 32'(halted), 32'd0);
        chk("halt.flush_ready", 32'(in_ready), 32'd1);

        // Flush with two buffered entries and a word on the input
        cycle(1'b1, 24'h211111, 8'd50, 1'b0, 1'b0, "fl0");
        cycle(1'b1, 24'h222222, 8'd51, 1'b0, 1'b0, "fl1");
        cycle(1'b1, 24'h233333, 8'd52, 1'b0, 1'b1, "fl2");
        chk("flush.out_valid", 32'(out_valid), 32'd0);
        cycle(1'b0, 24'h0, 8'd0, 1'b1, 1'b0, "fl3");
        chk("flush.dropped", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-stream
        cycle(1'b1, 24'h311111, 8'd60, 1'b0, 1'b0, "ar0");
        cycle(1'b1, 24'h322222, 8'd61, 1'b0, 1'b0, "ar1");
        #2 reset = 1'b0;
        #1;
        chk("areset.out_valid", 32'(out_valid), 32'd0);
        chk("areset.in_ready", 32'(in_ready), 32'd1);
        mq.delete();
        m_halted = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        cycle(1'b0, 24'h0, 8'd0, 1'b1, 1'b0, "ar_post");

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 3) != 0, 24'($urandom), PC_W'(i),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_decode_stage.md
# instr_decode_stage

Decode stage directly downstream of the PC/instruction ROM. Accepts 24-bit instruction words with their PC over a valid/ready handshake, buffers up to two entries in a skid buffer, and presents registered, fully decoded control fields to the execute stage. Supports pipeline flush from branch resolution and a sticky HALT state.

## Interface
Parameters:
- PC_W, 8, width of the program counter carried with each instruction
- DATA_W, 16, width of the sign-extended immediate

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  fetch offers an instruction
- in_instr  in  24  instruction word
- in_pc  in  PC_W  PC of in_instr
- in_ready  out  1  stage can accept this cycle
- flush  in  1  discard all held entries (branch redirect)
- out_valid  out  1  decoded entry presented
- out_ready  in  1  execute consumes entry
- out_pc  out  PC_W  PC of presented entry
- out_op  out  4  opcode
- out_rd, out_rs1, out_rs2  out  4 each  register indices
- out_imm  out  DATA_W  imm8 sign-extended
- out_reg_we, out_mem_re, out_mem_we, out_is_branch, out_is_jump, out_is_halt, out_illegal  out  1 each  decoded controls
- halted  out  1  stage is in HALTED state

## Operation
- Format: [23:20] op, [19:16] rd, [15:12] rs1, [11:8] rs2, [7:0] imm8.
- Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 ADDI, 7 LDI, 8 LD, 9 ST, A BEQ, B BNE, C JMP, D/E reserved, F HALT.
- reg_we for 1–8; mem_re for 8; mem_we for 9; is_branch for A,B; is_jump for C; is_halt for F; illegal for D,E (all other controls 0 for illegal).
- Decode is combinational on the write side; the skid buffer stores decoded fields, so outputs come straight from flops.
- Skid buffer: two entries (main, skid). Input transfer when in_valid & in_ready; output transfer when out_valid & out_ready. Order preserved.
- in_ready = !skid_full & state==RUN, registered (no combinational path from out_ready).
- FSM: RUN -> HALTED when a HALT instruction is accepted; HALTED -> RUN only on flush; reset -> RUN. In HALTED, in_ready=0 but buffered entries (including the HALT) still drain.
- flush: both entries invalidated, state to RUN; an input offered in the same cycle is dropped; an output transfer in the same cycle still counts as consumed.

## Timing
- Reset: out_valid=0, in_ready=1, halted=0, all out_* fields 0, state RUN, both entries empty.
- Latency: instruction accepted in cycle N appears with out_valid=1 in cycle N+1 when buffer was empty.
- Throughput: one per cycle with out_ready held high.
- out_ready low: first stalled entry held in main, next goes to skid; in_ready drops the cycle after skid fills; rises the cycle after skid drains.
- Outputs stable while out_valid=1 and out_ready=0.
- Simultaneous in and out transfer with one entry held: occupancy unchanged.
- Reset mid-operation: all entries discarded immediately (asynchronous).

## Structure
- Shared package decode_pkg: opcode enum (4-bit), field bit positions, decoded-entry struct (pc, op, rd, rs1, rs2, imm, controls).
- One sub-module: instr_decoder (combinational word -> struct); the stage instantiates it once on the input path.

## Test plan
- Reset then stream 0x1_3_4_5_00 (ADD), 0x6_2_1_0_FF (ADDI) at pc 0,1 with out_ready=1 -> outputs one cycle later; ADDI out_imm=0xFFFF, reg_we=1.
- Hold out_ready=0 while feeding 3 words -> in_ready falls after 2 accepted; releasing out_ready yields all 3 in order, none lost/duplicated.
- Feed 0xD00000 -> out_illegal=1, reg_we/mem_we/mem_re=0; 0x9xxxxx -> mem_we=1, reg_we=0.
- Feed HALT 0xF00000 then ADD -> HALT passed with is_halt=1, halted=1, in_ready=0, ADD never accepted; flush -> halted=0, in_ready=1.
- Two entries buffered, assert flush with in_valid=1 -> out_valid=0 next cycle, offered word dropped.
- Drop reset low mid-stream -> out_valid=0, in_ready=1 immediately, without clock edge.
